sm83_irq_ctl: RTL and testbench
===============================

# sm83_irq_ctl

Interrupt sequencer for the SM83 core. Tracks the interrupt master enable (IME), the EI delay and HALT state, and decides at each instruction boundary whether the control unit runs the normal opcode fetch or the 5-M-cycle interrupt dispatch. It resolves priority among pending requests and drives the one-hot `iack` and the jump vector. It sits beside `sm83_control` and replaces the core's constant `iack = 0`.

## Interface
Parameters:
- NUM_IRQS, 8, number of request lines; bit 0 has the highest priority.
- VEC_BASE, 8'h40, vector low byte for request 0.
- VEC_STRIDE, 8, vector spacing per request index.

Ports:
- clk  in  1  core clock.
- nreset  in  1  asynchronous, active-low reset.
- mcyc_end  in  1  one-clock strobe on the last clock of every M-cycle; all state advances only on clocks where this is 1.
- fetch  in  1  qualifies `mcyc_end`: the current M-cycle ends an instruction, so the next M-cycle is an opcode fetch.
- irq  in  NUM_IRQS  pending requests, already masked (IF & IE); level-sensitive.
- op_ei, op_di, op_reti, op_halt  in  1 each  decoded instruction effects, sampled with `mcyc_end`.
- ime  out  1  interrupt master enable.
- int_start  out  1  one-clock pulse: the next M-cycle is dispatch M1, not a fetch.
- disp_m  out  3  dispatch M-cycle index; 0 = not dispatching, 1..5 = M1..M5.
- vector  out  8  low byte of the dispatch target; high byte is 0.
- iack  out  NUM_IRQS  one-hot acknowledge pulse that clears the IF bit.
- halted  out  1  core is in HALT and the fetch is suppressed.
- pc_inc_inhibit  out  1  HALT-bug pulse (see Configuration).

## Operation
- States: RUN, HALT, D1, D2, D3, D4, D5. `disp_m` equals the D index, or 0 in RUN and HALT.
- All decisions use the registered `ime` as it was before the current `mcyc_end` takes effect.
- IME rules:
  - `op_di` clears `ime` and cancels a pending EI.
  - `op_ei` sets `ei_pend`. `ei_pend` moves into `ime` at the next `mcyc_end & fetch` after the one carrying `op_ei`. This gives a one-instruction delay.
  - `op_reti` sets `ime` immediately.
  - Entry into D1 clears `ime` and `ei_pend`.
- RUN, on `mcyc_end & fetch`:
  - If `ime & |irq`, go to D1 and pulse `int_start`.
  - Otherwise, if `op_halt`, go to HALT.
- HALT, on each `mcyc_end` with `|irq`:
  - If `ime`, go to D1 and pulse `int_start`.
  - Otherwise, go to RUN and resume fetching without dispatch.
  - `halted` = 1 while in HALT.
- Dispatch: D1 to D5 advance one state per `mcyc_end`; D5 returns to RUN.
  - On `mcyc_end` in D3 (after the PC-high push), sample `irq` and take the lowest set index `i`.
  - Then set `vector = VEC_BASE + i*VEC_STRIDE` and pulse `iack[i]`.
  - If `irq` is 0 at that sample (request withdrawn), set `vector = 8'h00` and keep `iack = 0`.
  - `vector` holds its value until the next D3 resolution.
- Simultaneous events:
  - `op_di` together with an accepted dispatch: the dispatch still occurs, and `ime` ends at 0.
  - `op_ei` together with `op_di`: DI wins.
- Reset (at any time, including mid-dispatch): go to RUN. Then `ime`, `ei_pend`, `int_start`, `disp_m`, `vector`, `iack`, `halted` and `pc_inc_inhibit` are all 0.

## Timing
- All outputs are registered and change on the clock edge that samples `mcyc_end`.
- `int_start` and `iack` are high for exactly one clock.
- Latency from a qualifying `mcyc_end` to `int_start`/`disp_m = 1`: 1 clock.
- `iack` and the new `vector` appear 1 clock after the D3 `mcyc_end`.
- `mcyc_end` low: no state change, and pulses deassert.

## Configuration
- `SM83_HALT_BUG_EN` defined:
  - `op_halt` with `ime = 0` and `|irq` does not enter HALT.
  - Instead, pulse `pc_inc_inhibit` for one clock, so that the next fetch does not increment PC.
- `SM83_HALT_BUG_EN` undefined:
  - That case enters HALT and immediately exits to RUN on the next `mcyc_end`.
  - `pc_inc_inhibit` is tied to 0.

## Structure
- Shared package `sm83_pkg`: the state enum `irq_state_t` (RUN, HALT, D1..D5), plus `NUM_IRQS`, `VEC_BASE` and `VEC_STRIDE` defaults.
- Sub-module `sm83_irq_prio`: combinational lowest-set-bit encoder producing index, valid flag and one-hot output; instantiated once.

## Test plan
- EI, NOP, then `irq = 8'h04` present throughout:
  - No dispatch after EI itself.
  - `int_start` follows the NOP's final `mcyc_end`.
  - `vector = 8'h50`, `iack = 8'h04`.
- `ime = 1`, `irq = 8'h1F`:
  - Dispatch resolves index 0, `vector = 8'h40`, `iack = 8'h01`.
  - `ime = 0` from D1 onward.
- `irq = 8'h02` at dispatch start, dropped to 0 before the D3 `mcyc_end`:
  - `vector = 8'h00`, `iack` stays 0.
  - Returns to RUN after D5.
- HALT with `ime = 0`, then `irq = 8'h08` three M-cycles later:
  - `halted` drops, state returns to RUN, no `int_start`.
  - With `SM83_HALT_BUG_EN`, HALT while already pending gives `pc_inc_inhibit` = 1 for one clock and `halted` stays 0.
- `nreset` asserted during D4:
  - All outputs 0 immediately, with no clock required.
  - After release, a fresh `ime = 1` request dispatches normally.

Source files
------------

// File: rtl/sm83_pkg.sv
// Shared SM83 interrupt definitions: sequencer state encoding and default
// request-line count and vector layout.
package sm83_pkg;

    localparam int         NUM_IRQS_DEF   = 8;
    localparam logic [7:0] VEC_BASE_DEF   = 8'h40;
    localparam int         VEC_STRIDE_DEF = 8;

    // D1..D5 are encoded as 1..5 so the state doubles as the dispatch M-cycle index.
    typedef enum logic [2:0] {
        RUN  = 3'd0,
        D1   = 3'd1,
        D2   = 3'd2,
        D3   = 3'd3,
        D4   = 3'd4,
        D5   = 3'd5,
        HALT = 3'd6
    } irq_state_t;

endpackage

// File: rtl/sm83_irq_prio.sv
// Lowest-set-bit priority encoder: bit 0 wins. Produces the index, a valid
// flag and a one-hot copy of the winner (all zero when nothing is requested).
module sm83_irq_prio #(
    parameter int NUM_IRQS = 8,
    parameter int IDX_W    = 3
) (
    input  logic [NUM_IRQS-1:0] req,
    output logic [IDX_W-1:0]    idx,
    output logic                valid,
    output logic [NUM_IRQS-1:0] onehot
);

    // Scanning downwards lets the lowest set bit overwrite any higher one.
    always_comb begin
        idx    = '0;
        onehot = '0;
        for (int i = NUM_IRQS - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx       = IDX_W'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/sm83_irq_ctl.sv
// SM83 interrupt sequencer: IME/EI delay, HALT, and the 5-M-cycle dispatch.
// Optional macro SM83_HALT_BUG_EN enables the HALT-bug (pc_inc_inhibit) behaviour.
module sm83_irq_ctl
    import sm83_pkg::*;
#(
    parameter int         NUM_IRQS   = NUM_IRQS_DEF,
    parameter logic [7:0] VEC_BASE   = VEC_BASE_DEF,
    parameter int         VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                mcyc_end,
    input  logic                fetch,
    input  logic [NUM_IRQS-1:0] irq,
    input  logic                op_ei,
    input  logic                op_di,
    input  logic                op_reti,
    input  logic                op_halt,
    output logic                ime,
    output logic                int_start,
    output logic [2:0]          disp_m,
    output logic [7:0]          vector,
    output logic [NUM_IRQS-1:0] iack,
    output logic                halted,
    output logic                pc_inc_inhibit
);

    localparam int IDX_W = (NUM_IRQS > 1) ? $clog2(NUM_IRQS) : 1;

    irq_state_t          state, state_n;
    logic                ei_pend, ei_pend_n, ime_n, int_start_n;
    logic [7:0]          vector_n, vec_calc;
    logic [NUM_IRQS-1:0] iack_n, prio_onehot;
    logic [IDX_W-1:0]    prio_idx;
    logic                prio_valid, any_irq, ime_eff, enter_disp;
`ifdef SM83_HALT_BUG_EN
    logic                pc_inh_n;
`endif

    sm83_irq_prio #(.NUM_IRQS(NUM_IRQS), .IDX_W(IDX_W)) u_prio (
        .req    (irq),
        .idx    (prio_idx),
        .valid  (prio_valid),
        .onehot (prio_onehot)
    );

    assign any_irq  = |irq;
    assign vec_calc = VEC_BASE + 8'(32'(prio_idx) * VEC_STRIDE);
    // A delayed EI becomes visible at the boundary that commits it, so EI;NOP
    // can dispatch right after the NOP; a DI on that boundary still cancels it.
    assign ime_eff  = ime | (ei_pend & fetch & ~op_di);

    always_comb begin
        state_n     = state;
        ime_n       = ime;
        ei_pend_n   = ei_pend;
        int_start_n = 1'b0;
        iack_n      = '0;
        vector_n    = vector;
        enter_disp  = 1'b0;
`ifdef SM83_HALT_BUG_EN
        pc_inh_n    = 1'b0;
`endif
        if (mcyc_end) begin
            if (fetch && ei_pend) begin
                ime_n     = 1'b1;
                ei_pend_n = 1'b0;
            end
            if (op_ei)   ei_pend_n = 1'b1;
            if (op_reti) ime_n     = 1'b1;
            if (op_di) begin
                ime_n     = 1'b0;
                ei_pend_n = 1'b0;
            end
            unique case (state)
                RUN: begin
                    if (fetch) begin
                        if (ime_eff && any_irq) begin
                            enter_disp = 1'b1;
                        end else if (op_halt) begin
`ifdef SM83_HALT_BUG_EN
                            if (any_irq) pc_inh_n = 1'b1;
                            else         state_n  = HALT;
`else
                            state_n = HALT;
`endif
                        end
                    end
                end
                HALT: begin
                    if (any_irq) begin
                        if (ime_eff) enter_disp = 1'b1;
                        else         state_n    = RUN;
                    end
                end
                D1: state_n = D2;
                D2: state_n = D3;
                D3: begin
                    state_n  = D4;
                    iack_n   = prio_onehot;
                    vector_n = prio_valid ? vec_calc : 8'h00;
                end
                D4: state_n = D5;
                D5: state_n = RUN;
                default: state_n = RUN;
            endcase
            if (enter_disp) begin
                state_n     = D1;
                int_start_n = 1'b1;
                ime_n       = 1'b0;
                ei_pend_n   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= RUN;
            ime       <= 1'b0;
            ei_pend   <= 1'b0;
            int_start <= 1'b0;
            vector    <= 8'h00;
            iack      <= '0;
        end else begin
            state     <= state_n;
            ime       <= ime_n;
            ei_pend   <= ei_pend_n;
            int_start <= int_start_n;
            vector    <= vector_n;
            iack      <= iack_n;
        end
    end

`ifdef SM83_HALT_BUG_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) pc_inc_inhibit <= 1'b0;
        else         pc_inc_inhibit <= pc_inh_n;
    end
`else
    assign pc_inc_inhibit = 1'b0;
`endif

    assign disp_m = (state inside {D1, D2, D3, D4, D5}) ? 3'(state) : 3'd0;
    assign halted = (state == HALT);

endmodule

// File: tb/tb_sm83_irq_ctl.sv
// Directed self-checking bench for sm83_irq_ctl; each M-cycle is two clocks
// with mcyc_end on the second one.
module tb_sm83_irq_ctl;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       mcyc_end = 1'b0, fetch = 1'b0;
    logic [7:0] irq = 8'h00;
    logic       op_ei = 1'b0, op_di = 1'b0, op_reti = 1'b0, op_halt = 1'b0;
    logic       ime, int_start, halted, pc_inc_inhibit;
    logic [2:0] disp_m;
    logic [7:0] vector, iack;

    int vectors = 0;
    int miscompares = 0;

    sm83_irq_ctl dut (
        .clk            (clk),
        .nreset         (nreset),
        .mcyc_end       (mcyc_end),
        .fetch          (fetch),
        .irq            (irq),
        .op_ei          (op_ei),
        .op_di          (op_di),
        .op_reti        (op_reti),
        .op_halt        (op_halt),
        .ime            (ime),
        .int_start      (int_start),
        .disp_m         (disp_m),
        .vector         (vector),
        .iack           (iack),
        .halted         (halted),
        .pc_inc_inhibit (pc_inc_inhibit)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // One M-cycle: a quiet clock, then the mcyc_end clock carrying the given effects.
    task automatic applyStimulus(input logic f, input logic ei, input logic di,
                                 input logic reti, input logic hlt, input logic [7:0] rq);
        @(negedge clk);
        mcyc_end = 1'b0; fetch = 1'b0;
        op_ei = 1'b0; op_di = 1'b0; op_reti = 1'b0; op_halt = 1'b0;
        irq = rq;
        @(negedge clk);
        mcyc_end = 1'b1; fetch = f;
        op_ei = ei; op_di = di; op_reti = reti; op_halt = hlt;
        @(posedge clk);
        #1;
        mcyc_end = 1'b0; fetch = 1'b0;
        op_ei = 1'b0; op_di = 1'b0; op_reti = 1'b0; op_halt = 1'b0;
    endtask

    task automatic idleClock();
        @(negedge clk);
        mcyc_end = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        checkOutput("rst_ime", ime, 0);
        checkOutput("rst_disp", disp_m, 0);
        checkOutput("rst_vec", vector, 0);
        checkOutput("rst_iack", iack, 0);
        checkOutput("rst_halt", halted, 0);
        checkOutput("rst_start", int_start, 0);
        checkOutput("rst_pcinh", pc_inc_inhibit, 0);
        @(negedge clk);
        nreset = 1'b1;

        // EI delay alone, then DI cancels a pending EI
        applyStimulus(1, 1, 0, 0, 0, 8'h00);
        checkOutput("ei_ime0", ime, 0);
        applyStimulus(1, 0, 0, 0, 0, 8'h00);
        checkOutput("ei_ime1", ime, 1);
        applyStimulus(1, 0, 1, 0, 0, 8'h00);
        checkOutput("di_ime", ime, 0);
        applyStimulus(1, 1, 0, 0, 0, 8'h00);
        applyStimulus(1, 1, 1, 0, 0, 8'h00);
        checkOutput("eidi_ime", ime, 0);
        applyStimulus(1, 0, 0, 0, 0, 8'h00);
        checkOutput("eidi_ime2", ime, 0);

        // EI, NOP with irq 0x04 throughout
        applyStimulus(1, 1, 0, 0, 0, 8'h04);
        checkOutput("t1_ei_start", int_start, 0);
        checkOutput("t1_ei_disp", disp_m, 0);
        applyStimulus(1, 0, 0, 0, 0, 8'h04);
        checkOutput("t1_start", int_start, 1);
        checkOutput("t1_d1", disp_m, 1);
        checkOutput("t1_ime", ime, 0);
        idleClock();
        checkOutput("t1_start_off", int_start, 0);
        checkOutput("t1_d1_hold", disp_m, 1);
        applyStimulus(0, 0, 0, 0, 0, 8'h04);
        checkOutput("t1_d2", disp_m, 2);
        applyStimulus(0, 0, 0, 0, 0, 8'h04);
        checkOutput("t1_d3", disp_m, 3);
        checkOutput("t1_iack_pre", iack, 0);
        applyStimulus(0, 0, 0, 0, 0, 8'h04);
        checkOutput("t1_d4", disp_m, 4);
        checkOutput("t1_vec", vector, 8'h50);
        checkOutput("t1_iack", iack, 8'h04);
        idleClock();
        checkOutput("t1_iack_off", iack, 0);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        checkOutput("t1_d5", disp_m, 5);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        checkOutput("t1_run", disp_m, 0);
        checkOutput("t1_vec_hold", vector, 8'h50);

        // ime=1 via RETI, irq 0x1F resolves index 0
        applyStimulus(1, 0, 0, 1, 0, 8'h00);
        checkOutput("t2_reti", ime, 1);
        applyStimulus(1, 0, 0, 0, 0, 8'h1F);
        checkOutput("t2_start", int_start, 1);
        checkOutput("t2_ime", ime, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 8'h1F);
        checkOutput("t2_vec", vector, 8'h40);
        checkOutput("t2_iack", iack, 8'h01);
        checkOutput("t2_ime_d4", ime, 0);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        checkOutput("t2_run", disp_m, 0);

        // irq withdrawn before the D3 sample
        applyStimulus(1, 0, 0, 1, 0, 8'h00);
        applyStimulus(1, 0, 0, 0, 0, 8'h02);
        checkOutput("t3_start", int_start, 1);
        applyStimulus(0, 0, 0, 0, 0, 8'h02);
        applyStimulus(0, 0, 0, 0, 0, 8'h02);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        checkOutput("t3_d4", disp_m, 4);
        checkOutput("t3_vec", vector, 8'h00);
        checkOutput("t3_iack", iack, 0);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        checkOutput("t3_run", disp_m, 0);

        // DI alongside an accepted dispatch: dispatch proceeds, ime ends 0
        applyStimulus(1, 0, 0, 1, 0, 8'h00);
        applyStimulus(1, 0, 1, 0, 0, 8'h06);
        checkOutput("t6_start", int_start, 1);
        checkOutput("t6_ime", ime, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 8'h06);
        checkOutput("t6_vec", vector, 8'h48);
        checkOutput("t6_iack", iack, 8'h02);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);

        // HALT with ime=0, woken by irq 0x08 three M-cycles later
        applyStimulus(1, 0, 0, 0, 1, 8'h00);
        checkOutput("t4_halted", halted, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 8'h00);
        checkOutput("t4_still", halted, 1);
        applyStimulus(0, 0, 0, 0, 0, 8'h08);
        checkOutput("t4_wake", halted, 0);
        checkOutput("t4_nostart", int_start, 0);
        checkOutput("t4_run", disp_m, 0);

        // HALT while a request is already pending with ime=0
        applyStimulus(1, 0, 0, 0, 1, 8'h08);
`ifdef SM83_HALT_BUG_EN
        checkOutput("t5_pcinh", pc_inc_inhibit, 1);
        checkOutput("t5_halted", halted, 0);
        idleClock();
        checkOutput("t5_pcinh_off", pc_inc_inhibit, 0);
`else
        checkOutput("t5_halted", halted, 1);
        checkOutput("t5_pcinh", pc_inc_inhibit, 0);
        applyStimulus(0, 0, 0, 0, 0, 8'h08);
        checkOutput("t5_exit", halted, 0);
        checkOutput("t5_nostart", int_start, 0);
`endif

        // Asynchronous reset during D4, then a fresh dispatch
        applyStimulus(1, 0, 0, 1, 0, 8'h00);
        applyStimulus(1, 0, 0, 0, 0, 8'h01);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 8'h01);
        checkOutput("t7_d4", disp_m, 4);
        checkOutput("t7_iack_pre", iack, 8'h01);
        nreset = 1'b0;
        #1;
        checkOutput("t7_rst_disp", disp_m, 0);
        checkOutput("t7_rst_iack", iack, 0);
        checkOutput("t7_rst_vec", vector, 0);
        checkOutput("t7_rst_ime", ime, 0);
        @(negedge clk);
        nreset = 1'b1;
        applyStimulus(1, 0, 0, 1, 0, 8'h00);
        applyStimulus(1, 0, 0, 0, 0, 8'h10);
        checkOutput("t7_start", int_start, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 8'h10);
        checkOutput("t7_vec", vector, 8'h60);
        checkOutput("t7_iack", iack, 8'h10);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        applyStimulus(0, 0, 0, 0, 0, 8'h00);
        checkOutput("t7_run", disp_m, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
